// File: rtl/button_event_ctrl.sv
// Button debouncer and event generator: synchronises a raw button level, debounces
// press/release and produces press, release, long-press and auto-repeat strobes.
module button_event_ctrl #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned LONG_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sync_q, btn_s;
  logic             ret_rep, ret_rep_d;
  logic             btn_out_d, press_d, release_d, long_d, repeat_d;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn_in;
      btn_s  <= sync_q;
    end
  end

  // State, shared counter, return flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ret_rep       <= 1'b0;
      btn_out       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ret_rep       <= ret_rep_d;
      btn_out       <= btn_out_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
    end
  end

  // Next-state, counter and strobe decode; every state entry clears the counter
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    ret_rep_d = ret_rep;
    btn_out_d = btn_out;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d   = HELD;
          cnt_d     = '0;
          press_d   = 1'b1;
          btn_out_d = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d   = DB_REL;
          cnt_d     = '0;
          ret_rep_d = 1'b0;
        end else if (cnt == LONG_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end
      end
      REPEAT: begin
        if (!btn_s) begin
          state_d   = DB_REL;
          cnt_d     = '0;
          ret_rep_d = 1'b1;
        end else if (cnt == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end
      end
      DB_REL: begin
        // A bounce back to pressed resumes the held state with a fresh count
        if (btn_s) begin
          state_d = ret_rep ? REPEAT : HELD;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          btn_out_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus queues expected strobes with their
// cycle stamps, a negedge monitor pops and compares each strobe the DUT raises.
module tb_button_event_ctrl;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_in;
  logic btn_out, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q[$];
  ev_t  ev;
  int   n_strb;
  int   act_kind;
  int   t0, t1, t2, t3, t4, t5, t6, p, l;

  button_event_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_out      (btn_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the expected queue in kind and cycle
  always @(negedge clk) begin
    n_strb = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
    if (n_strb > 1) begin
      n_checks++;
      n_errors++;
      $display("FAIL one_strobe: %0d strobes high at cycle %0d, at most 1 allowed", n_strb, cyc);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_strobe: kind %0d expected at cycle %0d not seen (now %0d)",
               exp_q[0].kind, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (n_strb >= 1) begin
      act_kind = press_pulse ? K_PRESS : release_pulse ? K_RELEASE :
                 long_pulse ? K_LONG : K_REPEAT;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", act_kind, cyc);
      end else begin
        ev = exp_q.pop_front();
        check("strobe_kind", act_kind, ev.kind);
        check("strobe_cycle", cyc, ev.cyc);
        check("strobe_btn_out", int'(btn_out), (ev.kind == K_RELEASE) ? 0 : 1);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_btn_out", int'(btn_out), 0);
    check("reset_strobes", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Short 2-cycle glitch is rejected
    t0 = cyc;
    btn_in = 1'b1;
    wait_until(t0 + 2);
    btn_in = 1'b0;
    wait_until(t0 + 20);
    check("bounce_btn_out", int'(btn_out), 0);

    // Clean press: strobe DB_CYCLES+2 edges after first sample
    t0 = cyc;
    btn_in = 1'b1;
    p = t0 + 7;
    push(K_PRESS, p);
    wait_until(p + 1);
    check("press_btn_out", int'(btn_out), 1);

    // Release bounce in HELD restarts the long-press count
    wait_until(p + 5);
    t1 = cyc;
    btn_in = 1'b0;
    wait_until(t1 + 2);
    btn_in = 1'b1;
    wait_until(t1 + 4);
    check("held_bounce_btn_out", int'(btn_out), 1);
    l = t1 + 21;
    push(K_LONG, l);
    push(K_REPEAT, l + 8);
    push(K_REPEAT, l + 16);
    push(K_REPEAT, l + 24);

    // Release bounce in REPEAT returns to REPEAT with a fresh period
    wait_until(l + 26);
    t2 = cyc;
    btn_in = 1'b0;
    wait_until(t2 + 2);
    btn_in = 1'b1;
    wait_until(t2 + 4);
    check("repeat_bounce_btn_out", int'(btn_out), 1);
    push(K_REPEAT, t2 + 13);
    push(K_REPEAT, t2 + 21);

    // Clean release
    wait_until(t2 + 22);
    t3 = cyc;
    btn_in = 1'b0;
    push(K_RELEASE, t3 + 7);
    wait_until(t3 + 8);
    check("release_btn_out", int'(btn_out), 0);

    // Asynchronous reset while in REPEAT with the button held through reset release
    wait_until(t3 + 12);
    t4 = cyc;
    btn_in = 1'b1;
    p = t4 + 7;
    push(K_PRESS, p);
    push(K_LONG, p + 16);
    wait_until(p + 19);
    check("pre_reset_btn_out", int'(btn_out), 1);
    check("pre_reset_queue", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_btn_out", int'(btn_out), 0);
    check("async_reset_strobes", int'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t5 = cyc;
    push(K_PRESS, t5 + 7);
    push(K_LONG, t5 + 23);
    wait_until(t5 + 25);
    check("post_reset_btn_out", int'(btn_out), 1);

    t6 = cyc;
    btn_in = 1'b0;
    push(K_RELEASE, t6 + 7);
    wait_until(t6 + 12);
    check("final_btn_out", int'(btn_out), 0);

    // Bounded drain of any outstanding expectations
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive stable cycles required to accept an edge (legal range 2..2^CNT_W-1).
REQ-002 SHALL have parameter LONG_CYCLES, default 16, meaning held cycles after accepted press before long_pulse (range 2..2^CNT_W-1).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 8, meaning period of repeat_pulse after long press (range 2..2^CNT_W-1).
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the shared cycle counter.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port btn_in  input  1  raw asynchronous button level, 1 = pressed.
REQ-008 SHALL have port btn_out  output  1  registered debounced button level.
REQ-009 SHALL have port press_pulse  output  1  one-cycle strobe on accepted press.
REQ-010 SHALL have port release_pulse  output  1  one-cycle strobe on accepted release.
REQ-011 SHALL have port long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYCLES.
REQ-012 SHALL have port repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES while held after long press.

Function
REQ-013 SHALL synchronise btn_in through two flip-flops; the FSM SHALL use only the second stage (btn_s).
REQ-014 SHALL use one shared counter cnt[CNT_W-1:0]; every state entry SHALL clear cnt to 0.
REQ-015 SHALL implement states IDLE, DB_PRESS, HELD, REPEAT, DB_REL.
REQ-016 IDLE: btn_s=1 -> DB_PRESS; otherwise stay.
REQ-017 DB_PRESS: btn_s=0 -> IDLE with no output strobe (bounce rejected); btn_s=1 with cnt=DB_CYCLES-1 -> HELD; otherwise cnt+1.
REQ-018 HELD: btn_s=0 -> DB_REL; btn_s=1 with cnt=LONG_CYCLES-1 -> REPEAT; otherwise cnt+1.
REQ-019 REPEAT: btn_s=0 -> DB_REL; btn_s=1 with cnt=REPEAT_CYCLES-1 -> cnt=0, stay; otherwise cnt+1.
REQ-020 DB_REL: btn_s=1 -> return to the held state it was entered from (HELD or REPEAT, kept in a 1-bit flag), cnt=0; btn_s=0 with cnt=DB_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-021 All strobes SHALL be registered and high exactly one cycle, in the cycle following the transition edge: press_pulse on DB_PRESS->HELD; long_pulse on HELD->REPEAT; repeat_pulse on each REPEAT wrap; release_pulse on DB_REL->IDLE.
REQ-022 btn_out SHALL go 1 with press_pulse and 0 with release_pulse; it SHALL stay 1 through DB_REL, including when the release bounce is rejected.
REQ-023 Press latency SHALL be DB_CYCLES+2 cycles from the first edge sampling btn_in=1 to press_pulse high, provided btn_in stays 1 throughout; release latency is the same, measured from the first sample of btn_in=0.
REQ-024 long_pulse SHALL be high LONG_CYCLES cycles after press_pulse; each repeat_pulse SHALL be high REPEAT_CYCLES cycles after the preceding long_pulse or repeat_pulse.
REQ-025 A rejected release bounce in DB_REL SHALL restart the held-state count from 0; long and repeat timing restarts, with no duplicate press_pulse.
REQ-026 At most one strobe SHALL be high in any cycle.
REQ-027 cnt SHALL never exceed the active limit minus 1, so no counter overflow or wrap-around is possible for legal parameters.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, both sync flops=0, the return flag=0 and all outputs=0, including mid-press or mid-debounce.
REQ-029 After rst_n deasserts with btn_in already 1, the block SHALL run a full press debounce and emit press_pulse after DB_CYCLES+2 cycles.

Verification
REQ-030 With defaults: btn_in 0->1, held 10 cycles -> press_pulse high exactly 6 cycles after the first sample high, btn_out=1, no other strobe.
REQ-031 btn_in high 2 cycles, then 0 -> no strobe, btn_out stays 0, FSM returns to IDLE.
REQ-032 Hold 40 cycles after press_pulse -> long_pulse 16 cycles after press_pulse, repeat_pulse at +24 and +32, plus one more every 8 cycles while held.
REQ-033 While held, btn_in 0 for 2 cycles then 1 -> no release_pulse, btn_out stays 1, long_pulse occurs 16 cycles after return to HELD.
REQ-034 Release -> release_pulse 6 cycles after the first sample low, btn_out=0.
REQ-035 Assert rst_n=0 while in REPEAT -> all outputs 0 immediately (asynchronously); with btn_in held 1 through release of reset -> new press_pulse 6 cycles after rst_n=1.
